imem_prog_loader: RTL and testbench

IMEM_PROG_LOADER -- requirements
Module: imem_prog_loader

---
 rtl/imem_prog_loader.sv | 131 +++++++++++++
 tb/tb_imem_prog_loader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/imem_prog_loader.sv
// Program loader: streams instruction words into instruction memory while holding the CPU in reset.
// Optional trailing checksum word verified against a running XOR: define LOADER_CHECKSUM_EN.
module imem_prog_loader #(
    parameter int PC_W    = 4,
    parameter int INSTR_W = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_data,
    input  logic               in_last,
    output logic               in_ready,
    output logic               mem_we,
    output logic [PC_W-1:0]    mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic [PC_W:0]      word_cnt,
    output logic [1:0]         err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
`ifdef LOADER_CHECKSUM_EN
        CHECK = 2'd2,
`endif
        DONE  = 2'd3
    } state_t;

    // Highest writable address; a non-last word landing here ends the load as an overflow.
    localparam logic [PC_W:0] LAST_ADDR = {1'b0, {PC_W{1'b1}}};

    state_t state, state_nxt;
    logic   accept, load_accept, load_end, start_ok;
    logic   err_ovf, err_csum;

    assign accept      = in_valid & in_ready;
    assign load_accept = accept && (state == LOAD);
    assign load_end    = load_accept && (in_last || word_cnt == LAST_ADDR);
    assign start_ok    = start && (state == IDLE || state == DONE);
    assign err         = {err_csum, err_ovf};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = LOAD;
            LOAD: begin
                if (load_end) begin
`ifdef LOADER_CHECKSUM_EN
                    state_nxt = CHECK;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: if (accept) state_nxt = DONE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        cpu_hold = 1'b1;
        done     = 1'b0;
        case (state)
            LOAD: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            CHECK: in_ready = 1'b1;
`endif
            DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            word_cnt  <= '0;
            err_ovf   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values of its neighbours.
            mem_we <= load_accept;
            if (start_ok) begin
                mem_addr <= '0;
                word_cnt <= '0;
                err_ovf  <= 1'b0;
            end else if (load_accept) begin
                mem_addr  <= word_cnt[PC_W-1:0];
                mem_wdata <= in_data;
                word_cnt  <= word_cnt + 1'b1;
                if (!in_last && word_cnt == LAST_ADDR) err_ovf <= 1'b1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [INSTR_W-1:0] xor_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_acc  <= '0;
            err_csum <= 1'b0;
        end else if (start_ok) begin
            xor_acc  <= '0;
            err_csum <= 1'b0;
        end else if (load_accept) begin
            xor_acc <= xor_acc ^ in_data;
        end else if (state == CHECK && accept && in_data != xor_acc) begin
            err_csum <= 1'b1;
        end
    end
`else
    assign err_csum = 1'b0;
`endif

endmodule

// File: tb/tb_imem_prog_loader.sv
// Randomized self-checking bench for imem_prog_loader; reference model is a word list plus running XOR.
// Honors LOADER_CHECKSUM_EN the same way the design does.
module tb_imem_prog_loader;

    localparam int PC_W    = 4;
    localparam int INSTR_W = 9;
    localparam int DEPTH   = 1 << PC_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               in_valid = 1'b0;
    logic [INSTR_W-1:0] in_data = '0;
    logic               in_last = 1'b0;
    logic               in_ready, mem_we, cpu_hold, done;
    logic [PC_W-1:0]    mem_addr;
    logic [INSTR_W-1:0] mem_wdata;
    logic [PC_W:0]      word_cnt;
    logic [1:0]         err;

    int n_vec = 0;
    int n_err = 0;
    logic [INSTR_W-1:0] words [DEPTH];

    imem_prog_loader #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done), .word_cnt(word_cnt), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One full program load. Words come from words[]; last_at < 0 means in_last is never set.
    task automatic do_load(input int last_at, input bit gappy, input bit midstart, input bit bad_csum);
        int                 i = 0;
        bit                 ended = 0, gap = 0, pv = 0;
        logic [PC_W-1:0]    pa = '0;
        logic [INSTR_W-1:0] pd = '0, x = '0;
        logic [1:0]         exp_err = 2'b00;

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("load_hold", cpu_hold, 1);
        check("load_done", done, 0);
        check("load_cnt0", word_cnt, 0);
        check("load_err0", err, 0);
        while (!ended) begin
            check("ready_load", in_ready, 1);
            check("we", mem_we, pv);
            if (pv) begin
                check("addr", mem_addr, pa);
                check("wdata", mem_wdata, pd);
            end
            start = midstart && (i == 2);
            if (gappy && gap) begin
                in_valid = 1'b0;
                pv = 0;
            end else begin
                in_valid = 1'b1;
                in_data  = words[i];
                in_last  = (i == last_at) ? 1'b1 : ($urandom_range(0, 3) == 0 && last_at < 0 && i < DEPTH - 1 ? 1'b0 : 1'b0);
                pv = 1;
                pa = PC_W'(i);
                pd = words[i];
                x  = x ^ words[i];
                if (i == last_at) ended = 1;
                else if (i == DEPTH - 1) begin
                    ended = 1;
                    exp_err[0] = 1'b1;
                end
                i++;
            end
            gap = ~gap;
            @(negedge clk);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("we_trail", mem_we, 1);
        check("addr_trail", mem_addr, pa);
        check("wdata_trail", mem_wdata, pd);
`ifdef LOADER_CHECKSUM_EN
        check("ready_check", in_ready, 1);
        check("done_check", done, 0);
        in_valid = 1'b1;
        in_data  = bad_csum ? (x ^ INSTR_W'($urandom_range(1, (1 << INSTR_W) - 1))) : x;
        in_last  = 1'($urandom_range(0, 1));
        if (bad_csum) exp_err[1] = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("we_check", mem_we, 0);
`else
        if (bad_csum) exp_err[1] = 1'b0;
`endif
        check("done", done, 1);
        check("hold_rel", cpu_hold, 0);
        check("ready_done", in_ready, 0);
        check("word_cnt", word_cnt, i);
        check("err", err, exp_err);
        @(negedge clk);
        check("we_after", mem_we, 0);
        check("done_stays", done, 1);
    endtask

    initial begin
        @(negedge clk);
        check("rst_hold", cpu_hold, 1);
        check("rst_done", done, 0);
        check("rst_we", mem_we, 0);
        check("rst_ready", in_ready, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_cnt", word_cnt, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("idle_hold", cpu_hold, 1);
            check("idle_done", done, 0);
            check("idle_we", mem_we, 0);
            check("idle_ready", in_ready, 0);
        end

        // Directed three-word program; its XOR is 0x0D0.
        words[0] = 9'h0A1; words[1] = 9'h0B2; words[2] = 9'h0C3;
        do_load(2, 0, 0, 0);
        do_load(2, 0, 0, 1);

        // Sixteen words with no in_last: overflow, no 17th write.
        for (int k = 0; k < DEPTH; k++) words[k] = INSTR_W'(k);
        do_load(-1, 0, 0, 0);

        // Gapped valid with start pulsed mid-load.
        for (int k = 0; k < DEPTH; k++) words[k] = INSTR_W'($urandom);
        do_load(5, 1, 1, 0);

        // Reset after two of four words.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = words[k];
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_cnt", word_cnt, 0);
        check("mid_rst_hold", cpu_hold, 1);
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_we", mem_we, 0);
            check("post_rst_hold", cpu_hold, 1);
        end
        do_load(3, 0, 0, 0);

        // Randomized programs.
        for (int r = 0; r < 30; r++) begin
            int n;
            for (int k = 0; k < DEPTH; k++) words[k] = INSTR_W'($urandom);
            n = $urandom_range(1, DEPTH);
            do_load((n == DEPTH && $urandom_range(0, 1) == 1) ? -1 : n - 1,
                    1'($urandom_range(0, 1)), (n >= 4) ? 1'($urandom_range(0, 1)) : 1'b0,
                    1'($urandom_range(0, 1)));
            for (int c = $urandom_range(0, 3); c > 0; c--) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
